// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle for prio_encoder_rr: event lines in, one index out via valid/ready,
// plus pending and sticky overflow status. master = encoder side, slave = source/consumer side.
interface prio_encoder_rr_if #(
  parameter int N = 8,
  parameter int W = ($clog2(N) < 1) ? 1 : $clog2(N)
);
  logic [N-1:0] req_in;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] pending;
  logic         ovf;
  logic         clr_ovf;

  modport master (
    input  req_in, out_ready, clr_ovf,
    output out_idx, out_valid, pending, ovf
  );

  modport slave (
    output req_in, out_ready, clr_ovf,
    input  out_idx, out_valid, pending, ovf
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Sticky request capture with fixed-priority or round-robin pick; pulse to out_valid is 2 edges.
// out_idx/out_valid hold while !out_ready; duplicate events on a pending, unacked line set ovf.
module prio_encoder_rr #(
  parameter int N       = 8,
  parameter int W       = ($clog2(N) < 1) ? 1 : $clog2(N),
  parameter int RR_MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  prio_encoder_rr_if.master bus
);
  logic [W-1:0] ptr;
  logic         ack;
  logic         load;
  logic         new_ovf;
  logic [N-1:0] ack_mask;
  logic [N-1:0] cand;
  logic [N-1:0] rot;
  logic [W:0]   base;
  logic [W:0]   rr_off;
  logic [W:0]   rr_sum;
  logic [W-1:0] sel_fixed;
  logic [W-1:0] sel_rr;
  logic [W-1:0] sel;

  always_comb begin
    ack      = bus.out_valid && bus.out_ready;
    ack_mask = '0;
    if (ack) ack_mask[bus.out_idx] = 1'b1;
    // candidates come from the registered vector only; same-cycle req_in waits a cycle
    cand     = bus.pending & ~ack_mask;
    new_ovf  = |(bus.req_in & cand);
    load     = !bus.out_valid || ack;
  end

  always_comb begin
    sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) sel_fixed = W'(i);
    end
  end

  // Rotate candidates so bit 0 is base, take the lowest set bit, then undo the rotation mod N.
  always_comb begin
    base = {1'b0, (ack ? bus.out_idx : ptr)} + (W+1)'(1);
    if (base == (W+1)'(N)) base = '0;
    rot    = N'({cand, cand} >> base);
    rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = (W+1)'(i);
    end
    rr_sum = base + rr_off;
    if (rr_sum >= (W+1)'(N)) rr_sum = rr_sum - (W+1)'(N);
    sel_rr = rr_sum[W-1:0];
  end

  assign sel = (RR_MODE != 0) ? sel_rr : sel_fixed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pending   <= '0;
      bus.out_idx   <= '0;
      bus.out_valid <= 1'b0;
      bus.ovf       <= 1'b0;
      ptr           <= W'(N - 1);
    end else begin
      bus.pending <= cand | bus.req_in;
      bus.ovf     <= (bus.ovf && !bus.clr_ovf) || new_ovf;
      if (ack) ptr <= bus.out_idx;
      if (load) begin
        if (|cand) begin
          bus.out_valid <= 1'b1;
          bus.out_idx   <= sel;
        end else begin
          bus.out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
